// File: rtl/box_crop_reader.sv
`default_nettype none
// ============================================================================
//  Module   : box_crop_reader
//  Purpose  : Reads the pixels inside a bounding box out of a BMP-ordered
//             frame buffer (bottom row first, 3 bytes per pixel, B,G,R) and
//             streams them row by row as 24-bit {R,G,B} words on a
//             valid/ready interface.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLOCK_50   in   1       single clock, rising edge
//    reset_n    in   1       asynchronous active-low reset
//    start      in   1       crop request, sampled only while idle
//    box        in   32      {xMin, xMax, yMin, yMax}
//    mem_rd_en  out  1       frame-buffer read strobe
//    mem_addr   out  ADDR_W  frame-buffer byte address
//    mem_rdata  in   8       read data, valid the cycle after mem_rd_en
//    pix_valid  out  1       pixel word / coordinates valid
//    pix_ready  in   1       downstream accepts the pixel
//    pix_data   out  24      {R,G,B}
//    pix_x      out  8       column relative to xMin
//    pix_y      out  8       row relative to yMin
//    crop_w     out  8       xMax-xMin+1 (mod 256), latched at start
//    crop_h     out  8       yMax-yMin+1 (mod 256), latched at start
//    busy       out  1       high whenever not idle
//    done       out  1       one-cycle end-of-job pulse
//    empty      out  1       qualifies done: box holds no pixels
//    err        out  1       qualifies done: box exceeds the image
// ============================================================================
module box_crop_reader #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 90,
  parameter int ADDR_W = 16
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              start,
  input  logic [31:0]       box,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [23:0]       pix_data,
  output logic [7:0]        pix_x,
  output logic [7:0]        pix_y,
  output logic [7:0]        crop_w,
  output logic [7:0]        crop_h,
  output logic              busy,
  output logic              done,
  output logic              empty,
  output logic              err
);

  // Address arithmetic constants, sized to the full address width so the
  // product never truncates before reaching mem_addr.
  localparam logic [ADDR_W-1:0] C_LAST_ROW = ADDR_W'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] C_WIDTH    = ADDR_W'(WIDTH);
  localparam logic [ADDR_W-1:0] C_BPP      = ADDR_W'(3);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_FETCH   = 3'd2,
    S_LAST    = 3'd3,
    S_PRESENT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t      state_q, state_d;

  // Latched box corners
  logic [7:0]  xmin_q, xmin_d;
  logic [7:0]  xmax_q, xmax_d;
  logic [7:0]  ymin_q, ymin_d;
  logic [7:0]  ymax_q, ymax_d;

  // Current pixel (absolute image coordinates) and colour-byte index
  logic [7:0]  cx_q, cx_d;
  logic [7:0]  cy_q, cy_d;
  logic [1:0]  c_q, c_d;

  // One-cycle read pipeline: which slot the returning byte belongs to
  logic        rd_pend_q, rd_pend_d;
  logic [1:0]  cap_c_q, cap_c_d;

  // Assembled pixel bytes
  logic [7:0]  b_q, b_d;
  logic [7:0]  g_q, g_d;
  logic [7:0]  r_q, r_d;

  // Job-level outputs
  logic [7:0]  crop_w_q, crop_w_d;
  logic [7:0]  crop_h_q, crop_h_d;
  logic        empty_q, empty_d;
  logic        err_q, err_d;

  // Combinational helpers
  logic              x_oob;
  logic              y_oob;
  logic [ADDR_W-1:0] row_from_bottom;
  logic [ADDR_W-1:0] pix_index;
  logic [ADDR_W-1:0] byte_addr;

  // --------------------------------------------------------------------------
  // Range check against the image size. Only the max corners need checking:
  // if a min corner is out of range while its max is in range, the box is
  // empty, which the next test catches.
  // --------------------------------------------------------------------------
  assign x_oob = int'(xmax_q) > (WIDTH - 1);
  assign y_oob = int'(ymax_q) > (HEIGHT - 1);

  // --------------------------------------------------------------------------
  // BMP stores the bottom image row first, so image row cy lives at buffer
  // row HEIGHT-1-cy.
  // --------------------------------------------------------------------------
  assign row_from_bottom = C_LAST_ROW - ADDR_W'(cy_q);
  assign pix_index       = row_from_bottom * C_WIDTH + ADDR_W'(cx_q);
  assign byte_addr       = pix_index * C_BPP + ADDR_W'(c_q);

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    xmin_d   = xmin_q;
    xmax_d   = xmax_q;
    ymin_d   = ymin_q;
    ymax_d   = ymax_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    c_d      = c_q;
    b_d      = b_q;
    g_d      = g_q;
    r_d      = r_q;
    crop_w_d = crop_w_q;
    crop_h_d = crop_h_q;
    empty_d  = empty_q;
    err_d    = err_q;

    // A read issued last cycle returns now; park it in its colour slot.
    rd_pend_d = (state_q == S_FETCH);
    cap_c_d   = c_q;
    if (rd_pend_q) begin
      case (cap_c_q)
        2'd0:    b_d = mem_rdata;
        2'd1:    g_d = mem_rdata;
        default: r_d = mem_rdata;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          xmin_d   = box[31:24];
          xmax_d   = box[23:16];
          ymin_d   = box[15:8];
          ymax_d   = box[7:0];
          crop_w_d = box[23:16] - box[31:24] + 8'd1;
          crop_h_d = box[7:0]   - box[15:8]  + 8'd1;
          empty_d  = 1'b0;
          err_d    = 1'b0;
          state_d  = S_CHECK;
        end
      end

      S_CHECK: begin
        if (x_oob || y_oob) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if ((xmin_q > xmax_q) || (ymin_q > ymax_q)) begin
          // Includes the upstream "nothing found" box {W-1,0,H-1,0}.
          empty_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cx_d    = xmin_q;
          cy_d    = ymin_q;
          c_d     = 2'd0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (c_q == 2'd2) begin
          c_d     = 2'd0;
          state_d = S_LAST;
        end else begin
          c_d = c_q + 2'd1;
        end
      end

      // R byte lands this cycle via the capture path above.
      S_LAST: begin
        state_d = S_PRESENT;
      end

      S_PRESENT: begin
        if (pix_ready) begin
          if (cx_q != xmax_q) begin
            cx_d    = cx_q + 8'd1;
            state_d = S_FETCH;
          end else if (cy_q != ymax_q) begin
            cx_d    = xmin_q;
            cy_d    = cy_q + 8'd1;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      xmin_q    <= 8'd0;
      xmax_q    <= 8'd0;
      ymin_q    <= 8'd0;
      ymax_q    <= 8'd0;
      cx_q      <= 8'd0;
      cy_q      <= 8'd0;
      c_q       <= 2'd0;
      rd_pend_q <= 1'b0;
      cap_c_q   <= 2'd0;
      b_q       <= 8'd0;
      g_q       <= 8'd0;
      r_q       <= 8'd0;
      crop_w_q  <= 8'd0;
      crop_h_q  <= 8'd0;
      empty_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      xmin_q    <= xmin_d;
      xmax_q    <= xmax_d;
      ymin_q    <= ymin_d;
      ymax_q    <= ymax_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      c_q       <= c_d;
      rd_pend_q <= rd_pend_d;
      cap_c_q   <= cap_c_d;
      b_q       <= b_d;
      g_q       <= g_d;
      r_q       <= r_d;
      crop_w_q  <= crop_w_d;
      crop_h_q  <= crop_h_d;
      empty_q   <= empty_d;
      err_q     <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Address and pixel fields are forced to zero when not qualified
  // so the bus is quiet outside reads / valid pixels (and 0 out of reset,
  // where the coordinate registers would otherwise decode to a real address).
  // --------------------------------------------------------------------------
  assign mem_rd_en = (state_q == S_FETCH);
  assign mem_addr  = mem_rd_en ? byte_addr : '0;

  assign pix_valid = (state_q == S_PRESENT);
  assign pix_data  = pix_valid ? {r_q, g_q, b_q} : 24'd0;
  assign pix_x     = pix_valid ? (cx_q - xmin_q) : 8'd0;
  assign pix_y     = pix_valid ? (cy_q - ymin_q) : 8'd0;

  assign crop_w    = crop_w_q;
  assign crop_h    = crop_h_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign empty     = empty_q;
  assign err       = err_q;

endmodule
`default_nettype wire
